// File: rtl/dmem_responder.sv
// Data-memory responder for the execute stage load/store port.
// Word-wide synchronous RAM; sub-word stores use read-modify-write.
module dmem_responder #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    state_t state;

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rd_q;

    logic [IDX_W-1:0] a_idx;
    logic [1:0]       a_off;
    logic [1:0]       a_sz;
    logic             a_store;
    logic [XLEN-1:0]  a_wdata;

    logic [IDX_W-1:0] in_idx;
    logic [1:0]       in_off;
    logic             f3_ok;
    logic             mis;
    logic             oor;
    logic             in_err;
    logic             accept;

    logic [IDX_W-1:0] ram_idx;
    logic             re;
    logic             we;
    logic [XLEN-1:0]  mask;
    logic [XLEN-1:0]  wr_word;
    logic [XLEN-1:0]  ld_shift;
    logic [XLEN-1:0]  ld_data;

    // Request decode and error classification at the accept point
    always_comb begin
        in_idx = req_addr[IDX_W+1:2];
        in_off = req_addr[1:0];
        f3_ok  = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_store;
            default:                f3_ok = 1'b0;
        endcase
        mis = ((req_funct3[1:0] == 2'b01) && (in_off == 2'b11))
           || ((req_funct3[1:0] == 2'b10) && (in_off != 2'b00));
        oor    = |req_addr[XLEN-1:IDX_W+2];
        in_err = !f3_ok || mis || oor;
        accept = req_valid && req_ready;
    end

    // RAM port control, store merge and load lane alignment
    always_comb begin
        ram_idx  = (state == IDLE) ? in_idx : a_idx;
        re       = accept && !in_err;
        we       = (state == WR);
        case (a_sz)
            2'b00:   mask = XLEN'(8'hFF);
            2'b01:   mask = XLEN'(16'hFFFF);
            default: mask = '1;
        endcase
        mask     = mask << {a_off, 3'b000};
        wr_word  = (rd_q & ~mask)
                 | ((a_wdata << {a_off, 3'b000}) & mask);
        ld_shift = rd_q >> {a_off, 3'b000};
        case (a_sz)
            2'b00:   ld_data = {ld_shift[7:0], {(XLEN-8){1'b0}}};
            2'b01:   ld_data = {ld_shift[15:0], {(XLEN-16){1'b0}}};
            default: ld_data = rd_q;
        endcase
    end

    // Single-port synchronous RAM; read is issued at the accept edge
    always_ff @(posedge clk) begin
        if (we) mem[ram_idx] <= wr_word;
        if (re) rd_q <= mem[ram_idx];
    end

    // Transaction FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            a_idx      <= '0;
            a_off      <= '0;
            a_sz       <= '0;
            a_store    <= 1'b0;
            a_wdata    <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_idx     <= in_idx;
                        a_off     <= in_off;
                        a_sz      <= req_funct3[1:0];
                        a_store   <= req_store;
                        a_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (in_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else if (req_store && req_funct3[1:0] == 2'b10) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (a_store) begin
                        state <= WR;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= ld_data;
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder.
// Table of single transactions plus reset and back-to-back sequences.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    int checks;
    int failures;

    dmem_responder #(
        .XLEN (32),
        .DEPTH(1024),
        .IDX_W(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
        int          lat;
    } vec_t;

    vec_t v[19];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    task automatic txn(input string nm, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input logic err,
                       input int lat);
        int n;
        wait_ready();
        drive(st, f3, addr, wd);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0BAD_0BAD;
        req_funct3 = 3'b111;
        n = 1;
        while (!resp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_valid"}, {31'b0, resp_valid}, 32'd1);
        chk({nm, "_lat"}, n, lat);
        chk({nm, "_data"}, resp_data, exp);
        chk({nm, "_err"}, {31'b0, resp_err}, {31'b0, err});
    endtask

    logic [31:0] pexp [4];
    vec_t        pv [4];

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;

        v[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0, 1'b0, 2};
        v[1]  = '{1'b0, 3'b010, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0, 2};
        v[2]  = '{1'b0, 3'b000, 32'h11,  32'h0, 32'hBE000000, 1'b0, 2};
        v[3]  = '{1'b0, 3'b101, 32'h12,  32'h0, 32'hDEAD0000, 1'b0, 2};
        v[4]  = '{1'b0, 3'b001, 32'h11,  32'h0, 32'hADBE0000, 1'b0, 2};
        v[5]  = '{1'b1, 3'b000, 32'h12,  32'h1234565A, 32'h0, 1'b0, 3};
        v[6]  = '{1'b0, 3'b010, 32'h10,  32'h0, 32'hDE5ABEEF, 1'b0, 2};
        v[7]  = '{1'b0, 3'b001, 32'h13,  32'h0, 32'h0, 1'b1, 1};
        v[8]  = '{1'b0, 3'b010, 32'h12,  32'h0, 32'h0, 1'b1, 1};
        v[9]  = '{1'b0, 3'b011, 32'h10,  32'h0, 32'h0, 1'b1, 1};
        v[10] = '{1'b1, 3'b000, 32'h1000, 32'hFF, 32'h0, 1'b1, 1};
        v[11] = '{1'b1, 3'b101, 32'h10,  32'hFFFF, 32'h0, 1'b1, 1};
        v[12] = '{1'b1, 3'b010, 32'h11,  32'hFFFFFFFF, 32'h0, 1'b1, 1};
        v[13] = '{1'b0, 3'b010, 32'h10,  32'h0, 32'hDE5ABEEF, 1'b0, 2};
        v[14] = '{1'b0, 3'b100, 32'h13,  32'h0, 32'hDE000000, 1'b0, 2};
        v[15] = '{1'b1, 3'b010, 32'hFFC, 32'h11223344, 32'h0, 1'b0, 2};
        v[16] = '{1'b0, 3'b010, 32'hFFC, 32'h0, 32'h11223344, 1'b0, 2};
        v[17] = '{1'b0, 3'b000, 32'hFFF, 32'h0, 32'h11000000, 1'b0, 2};
        v[18] = '{1'b0, 3'b101, 32'hFFE, 32'h0, 32'h11220000, 1'b0, 2};

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            txn($sformatf("vec%0d", i), v[i].st, v[i].f3, v[i].addr,
                v[i].wd, v[i].exp, v[i].err, v[i].lat);
        end

        // SH interrupted by reset while in RD: no write lands
        wait_ready();
        drive(1'b1, 3'b001, 32'h10, 32'h0000CAFE);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rd_busy", {31'b0, busy}, 32'd1);
        chk("rd_ready", {31'b0, req_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("rstrd_ready", {31'b0, req_ready}, 32'd1);
        chk("rstrd_valid", {31'b0, resp_valid}, 32'd0);
        chk("rstrd_busy", {31'b0, busy}, 32'd0);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        txn("after_rd_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDE5ABEEF, 1'b0, 2);

        // SH interrupted by reset in RESP: write already done
        wait_ready();
        drive(1'b1, 3'b001, 32'h10, 32'h0000CAFE);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("resp_seen", {31'b0, resp_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstresp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rstresp_ready", {31'b0, req_ready}, 32'd1);
        chk("rstresp_data", resp_data, 32'd0);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        txn("after_resp_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDE5ACAFE, 1'b0, 2);

        // req_valid held high across four loads, junk inputs while busy
        pv[0] = '{1'b0, 3'b010, 32'h10,  32'h0, 32'hDE5ACAFE, 1'b0, 2};
        pv[1] = '{1'b0, 3'b000, 32'h10,  32'h0, 32'hFE000000, 1'b0, 2};
        pv[2] = '{1'b0, 3'b101, 32'hFFE, 32'h0, 32'h11220000, 1'b0, 2};
        pv[3] = '{1'b0, 3'b010, 32'hFFC, 32'h0, 32'h11223344, 1'b0, 2};
        for (int i = 0; i < 4; i++) pexp[i] = pv[i].exp;
        begin
            int acc;
            int nresp;
            int bad_rb;
            logic was_ready;
            acc    = 0;
            nresp  = 0;
            bad_rb = 0;
            wait_ready();
            drive(pv[0].st, pv[0].f3, pv[0].addr, pv[0].wd);
            for (int c = 0; c < 40 && nresp < 4; c++) begin
                was_ready = req_ready;
                @(posedge clk);
                #1;
                if (was_ready && req_valid) acc++;
                if (req_ready == busy) bad_rb++;
                if (resp_valid) begin
                    if (nresp < 4)
                        chk($sformatf("b2b%0d", nresp), resp_data, pexp[nresp]);
                    nresp++;
                end
                if (acc >= 4) begin
                    req_valid = 1'b0;
                end else if (req_ready) begin
                    drive(pv[acc].st, pv[acc].f3, pv[acc].addr, pv[acc].wd);
                end else begin
                    drive(1'b1, 3'b011, 32'h13 + c, 32'hA5A5A5A5);
                end
            end
            req_valid = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (resp_valid) nresp++;
            end
            chk("b2b_count", nresp, 32'd4);
            chk("b2b_ready_busy", bad_rb, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the execute stage's load/store interface.
- Accepts one request per transaction: byte address from the ALU result, store flag, funct3 and store data.
- Reads or writes an internal word-wide single-port synchronous RAM. Sub-word stores are done by read-modify-write.
- Returns load data in the top-aligned lane format the execute stage consumes. Sign or zero extension is done by the execute stage, not here.

Parameters:
XLEN, 32, data and address width
DEPTH, 1024, number of 32-bit words in the internal RAM
IDX_W, 10, word-index width; must equal clog2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready at a rising edge
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data; SB uses [7:0], SH uses [15:0]
resp_valid  output  1  one-cycle pulse; transaction complete
resp_data  output  XLEN  load data, top-aligned; valid while resp_valid is high
resp_err  output  1  qualified by resp_valid; misaligned, out-of-range or illegal funct3
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, busy=0. RAM contents are not reset.
- Storage is little-endian. The byte at offset k of a word is word[8k+7:8k]. Word index = req_addr[IDX_W+1:2].
- Request fields (addr, store, funct3, wdata) are latched at acceptance. Later input changes are ignored.
- Error checks, evaluated at acceptance:
  - illegal funct3 (011, 110, 111; or 100/101 with req_store=1) -> error
  - H/HU with addr[1:0]==11 -> error
  - W with addr[1:0]!=00 -> error
  - req_addr[XLEN-1:IDX_W+2] nonzero -> error
  - On error: go straight to RESP with resp_err=1 and resp_data=0. No RAM access occurs.
- States:
  - IDLE: req_ready=1. On accept:
    - error -> RESP
    - load -> RD
    - SW -> WR
    - SB/SH -> RD
  - RD: RAM read issued; data is registered and available next cycle.
    - load -> RESP
    - store -> WR
  - WR: one RAM write at the rising edge leaving this state.
    - SW writes wdata.
    - SB/SH merge the selected lane(s) into the word read in RD; other bytes are preserved.
    - Next state RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Load data format:
  - LB/LBU: resp_data = {selected byte, 24'b0}
  - LH/LHU: resp_data = {selected half, 16'b0}; the half at offset o is bytes o+1:o, with byte o+1 in [31:24]
  - LW: resp_data = word
  - Stores: resp_data = 0
- Latency, counted from the accept edge to the cycle resp_valid is high:
  - error: 1 cycle
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
- Throughput: the next request can be accepted in the cycle after RESP, when IDLE has returned and req_ready=1.
- resp_data and resp_err hold their values after RESP until the next RESP.
- Reset mid-operation: return to IDLE immediately. A store is either fully written (its WR edge already occurred) or not written at all; no partial merge can land.
- A back-to-back load of an address stored by the previous transaction returns the new data; no bypass is needed.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_data=0xDEADBEEF, resp_err=0; resp_valid exactly 2 cycles after each accept edge.
- After the above, LB @0x11 -> 0xBE000000; LHU @0x12 -> 0xDEAD0000; LH @0x11 -> 0xADBE0000.
- SB wdata=0x1234565A @0x12 (resp_valid 3 cycles after accept), then LW @0x10 -> 0xDE5ABEEF.
- LH @0x13, LW @0x12, funct3=011, SB with addr=DEPTH*4 -> each gives resp_err=1, resp_data=0, resp_valid 1 cycle after accept; no RAM change (LW @0x10 still 0xDE5ABEEF).
- SH 0xCAFE @0x10, reset asserted while in RD -> req_ready=1 and resp_valid=0 immediately; LW @0x10 still 0xDE5ABEEF. Repeat with reset asserted in RESP -> word reads 0xDE5ACAFE.
- req_valid held high across 4 loads -> req_ready low except in IDLE; exactly 4 resp_valid pulses in order; inputs changed mid-transaction do not affect the result.
